gn_mdl_axis_slv_pkt: RTL and testbench



---
 rtl/gn_mdl_axis_pkg.sv | 26 ++
 rtl/gn_mdl_axis_trdy_gen.sv | 73 +++++++
 rtl/gn_mdl_axis_slv_pkt.sv | 142 ++++++++++++++
 tb/tb_gn_mdl_axis_slv_pkt.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gn_mdl_axis_pkg.sv
// Shared types and helpers for the AXI4-Stream packet sink model.
package gn_mdl_axis_pkg;

  typedef enum logic [1:0] {
    ALWAYS  = 2'd0,
    RANDOM  = 2'd1,
    PATTERN = 2'd2,
    PKT_GAP = 2'd3
  } trdy_mode_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Widest tkeep supported (512-bit tdata)
  localparam int unsigned KEEP_MAX = 64;

  function automatic logic [31:0] popcount_keep(input logic [KEEP_MAX-1:0] keep);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + 32'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gn_mdl_axis_trdy_gen.sv
// tready gate shaper: ALWAYS / RANDOM (LFSR) / PATTERN (on-off) / PKT_GAP (idle after tlast).
module gn_mdl_axis_trdy_gen
  import gn_mdl_axis_pkg::*;
#(
  parameter int unsigned P_ON_CYC  = 4,
  parameter int unsigned P_OFF_CYC = 2,
  parameter int unsigned P_GAP_CYC = 3,
  parameter logic [15:0] P_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic [7:0] thr,
  input  logic       tlast_hs,
  output logic       gate
);

  localparam int unsigned PAT_LEN = P_ON_CYC + P_OFF_CYC;
  localparam int unsigned PW      = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned GW      = (P_GAP_CYC > 0) ? $clog2(P_GAP_CYC + 1) : 1;
  localparam logic [15:0] SEED    = (P_SEED == 16'h0000) ? 16'h0001 : P_SEED;

  trdy_mode_e    mode_e;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          gate_q, gate_d;

  assign mode_e = trdy_mode_e'(mode);
  assign gate   = gate_q;

  // Pattern and gap counters idle at zero outside their own mode, so entering
  // PATTERN always starts in the ON phase.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    pat_d  = '0;
    gap_d  = '0;
    gate_d = 1'b1;
    case (mode_e)
      RANDOM: begin
        gate_d = ({1'b0, lfsr_q[6:0]} < thr);
      end
      PATTERN: begin
        gate_d = (pat_q < PW'(P_ON_CYC));
        pat_d  = (pat_q == PW'(PAT_LEN - 1)) ? '0 : pat_q + PW'(1);
      end
      PKT_GAP: begin
        if (tlast_hs) begin
          gap_d = GW'(P_GAP_CYC);
        end else if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end
        gate_d = (gap_d == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
      pat_q  <= '0;
      gap_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      pat_q  <= pat_d;
      gap_q  <= gap_d;
      gate_q <= gate_d;
    end
  end

endmodule

// File: rtl/gn_mdl_axis_slv_pkt.sv
// Packet-aware AXI4-Stream sink model: circular capture buffer, shaped tready,
// protocol checks and beat/byte/packet statistics.
module gn_mdl_axis_slv_pkt
  import gn_mdl_axis_pkg::*;
#(
  parameter int unsigned P_DWIDTH  = 32,
  parameter int unsigned P_UWIDTH  = 1,
  parameter int unsigned P_DEPTH   = 16,
  parameter int unsigned P_ON_CYC  = 4,
  parameter int unsigned P_OFF_CYC = 2,
  parameter int unsigned P_GAP_CYC = 3,
  parameter logic [15:0] P_SEED    = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [P_DWIDTH-1:0]        rx_axis_tdata,
  input  logic [P_DWIDTH/8-1:0]      rx_axis_tkeep,
  input  logic                       rx_axis_tlast,
  input  logic [P_UWIDTH-1:0]        rx_axis_tuser,
  input  logic                       rx_axis_tvalid,
  output logic                       rx_axis_tready,
  input  logic [1:0]                 cfg_mode,
  input  logic [7:0]                 cfg_rnd_thr,
  input  logic                       rd_en,
  output logic [P_DWIDTH-1:0]        rd_data,
  output logic [P_DWIDTH/8-1:0]      rd_keep,
  output logic                       rd_last,
  output logic [P_UWIDTH-1:0]        rd_user,
  output logic                       rd_empty,
  output logic [$clog2(P_DEPTH):0]   fill_level,
  output logic [31:0]                beat_cnt,
  output logic [31:0]                byte_cnt,
  output logic [31:0]                pkt_cnt,
  output logic                       err_stable,
  output logic                       err_keep,
  input  logic                       err_clr
);

  localparam int unsigned KW = P_DWIDTH / 8;
  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = P_DWIDTH + KW + 1 + P_UWIDTH;

  logic [BW-1:0]       mem_q [P_DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [31:0]         beat_q, beat_d, byte_q, byte_d, pkt_q, pkt_d;
  logic                err_stable_q, err_stable_d, err_keep_q, err_keep_d;
  logic                stall_q;
  logic [P_DWIDTH-1:0] prev_data_q;
  logic [KW-1:0]       prev_keep_q;
  logic                prev_last_q;
  logic [P_UWIDTH-1:0] prev_user_q;

  logic gate, full_c, empty_c, hs_c, pop_c, chg_c, stable_set_c, keep_set_c;

  gn_mdl_axis_trdy_gen #(
    .P_ON_CYC  (P_ON_CYC),
    .P_OFF_CYC (P_OFF_CYC),
    .P_GAP_CYC (P_GAP_CYC),
    .P_SEED    (P_SEED)
  ) u_trdy_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (cfg_mode),
    .thr      (cfg_rnd_thr),
    .tlast_hs (hs_c & rx_axis_tlast),
    .gate     (gate)
  );

  assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_c = (wptr_q == rptr_q);

  // tready comes from registered state only, never from tvalid
  assign rx_axis_tready = gate & ~full_c;
  assign hs_c           = rx_axis_tvalid & rx_axis_tready;
  assign pop_c          = rd_en & ~empty_c;

  assign {rd_data, rd_keep, rd_last, rd_user} = mem_q[rptr_q[AW-1:0]];
  assign rd_empty   = empty_c;
  assign fill_level = wptr_q - rptr_q;
  assign beat_cnt   = beat_q;
  assign byte_cnt   = byte_q;
  assign pkt_cnt    = pkt_q;
  assign err_stable = err_stable_q;
  assign err_keep   = err_keep_q;

  assign chg_c = (rx_axis_tdata != prev_data_q) | (rx_axis_tkeep != prev_keep_q) |
                 (rx_axis_tlast != prev_last_q) | (rx_axis_tuser != prev_user_q);
  assign stable_set_c = stall_q & (~rx_axis_tvalid | chg_c);
  assign keep_set_c   = hs_c & ((rx_axis_tkeep == '0) | (~rx_axis_tlast & (rx_axis_tkeep != '1)));

  // Next-state for pointers, statistics and sticky errors (set beats clear)
  always_comb begin
    wptr_d       = wptr_q + PW'(hs_c);
    rptr_d       = rptr_q + PW'(pop_c);
    beat_d       = beat_q + 32'(hs_c);
    byte_d       = byte_q;
    pkt_d        = pkt_q + 32'(hs_c & rx_axis_tlast);
    err_stable_d = stable_set_c | (err_stable_q & ~err_clr);
    err_keep_d   = keep_set_c | (err_keep_q & ~err_clr);
    if (hs_c) begin
      byte_d = byte_q + popcount_keep(KEEP_MAX'(rx_axis_tkeep));
    end
  end

  always_ff @(posedge clk) begin
    if (hs_c) begin
      mem_q[wptr_q[AW-1:0]] <= {rx_axis_tdata, rx_axis_tkeep, rx_axis_tlast, rx_axis_tuser};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      beat_q       <= '0;
      byte_q       <= '0;
      pkt_q        <= '0;
      err_stable_q <= 1'b0;
      err_keep_q   <= 1'b0;
      stall_q      <= 1'b0;
      prev_data_q  <= '0;
      prev_keep_q  <= '0;
      prev_last_q  <= 1'b0;
      prev_user_q  <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      beat_q       <= beat_d;
      byte_q       <= byte_d;
      pkt_q        <= pkt_d;
      err_stable_q <= err_stable_d;
      err_keep_q   <= err_keep_d;
      stall_q      <= rx_axis_tvalid & ~rx_axis_tready;
      prev_data_q  <= rx_axis_tdata;
      prev_keep_q  <= rx_axis_tkeep;
      prev_last_q  <= rx_axis_tlast;
      prev_user_q  <= rx_axis_tuser;
    end
  end

endmodule

// File: tb/tb_gn_mdl_axis_slv_pkt.sv
// Bench for gn_mdl_axis_slv_pkt: queue-based reference model plus directed tests.
module tb_gn_mdl_axis_slv_pkt;

  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = 4;
  localparam int unsigned UW    = 1;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic          tlast = 1'b0;
  logic [UW-1:0] tuser = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [1:0]    cfg_mode = 2'd0;
  logic [7:0]    cfg_rnd_thr = 8'd0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic [KW-1:0] rd_keep;
  logic          rd_last;
  logic [UW-1:0] rd_user;
  logic          rd_empty;
  logic [LW-1:0] fill_level;
  logic [31:0]   beat_cnt, byte_cnt, pkt_cnt;
  logic          err_stable, err_keep;
  logic          err_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gn_mdl_axis_slv_pkt #(
    .P_DWIDTH(32), .P_UWIDTH(1), .P_DEPTH(16),
    .P_ON_CYC(4), .P_OFF_CYC(2), .P_GAP_CYC(3), .P_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep), .rx_axis_tlast(tlast),
    .rx_axis_tuser(tuser), .rx_axis_tvalid(tvalid), .rx_axis_tready(tready),
    .cfg_mode(cfg_mode), .cfg_rnd_thr(cfg_rnd_thr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last),
    .rd_user(rd_user), .rd_empty(rd_empty), .fill_level(fill_level),
    .beat_cnt(beat_cnt), .byte_cnt(byte_cnt), .pkt_cnt(pkt_cnt),
    .err_stable(err_stable), .err_keep(err_keep), .err_clr(err_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_beats = '0, m_bytes = '0, m_pkts = '0;
  logic        m_err_s = 1'b0, m_err_k = 1'b0;
  logic        m_stall = 1'b0;
  beat_t       m_prev = '0;
  logic        seen_tready = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_beats = '0; m_bytes = '0; m_pkts = '0;
      m_err_s = 1'b0; m_err_k = 1'b0; m_stall = 1'b0; m_prev = '0;
    end else begin
      logic  hs, do_pop, k_bad, s_bad;
      int    ones;
      beat_t cur;
      cur    = {tdata, tkeep, tlast, tuser};
      hs     = tvalid && seen_tready;
      do_pop = rd_en && (mq.size() > 0);
      s_bad  = m_stall && (!tvalid || (cur != m_prev));
      k_bad  = 1'b0;
      if (hs) begin
        ones = 0;
        for (int i = 0; i < KW; i++) if (tkeep[i]) ones++;
        m_beats = m_beats + 32'd1;
        m_bytes = m_bytes + 32'(ones);
        if (tlast) m_pkts = m_pkts + 32'd1;
        k_bad = (ones == 0) || (!tlast && ones != KW);
        mq.push_back(cur);
        $display("[TB] hs t=%0t data=%08h keep=%h last=%0b fill=%0d",
                 $time, tdata, tkeep, tlast, mq.size() - (do_pop ? 1 : 0));
      end
      if (do_pop) void'(mq.pop_front());
      m_err_s = s_bad ? 1'b1 : (err_clr ? 1'b0 : m_err_s);
      m_err_k = k_bad ? 1'b1 : (err_clr ? 1'b0 : m_err_k);
      m_stall = tvalid && !seen_tready;
      m_prev  = cur;
    end
  end

  // Every cycle: compare DUT outputs against the model, away from the active edge
  always @(negedge clk) begin
    seen_tready = tready;
    check("m_fill", 64'(fill_level), 64'(mq.size()));
    check("m_empty", 64'(rd_empty), 64'(mq.size() == 0));
    if (mq.size() > 0) begin
      check("m_rd_data", 64'(rd_data), 64'(mq[0].d));
      check("m_rd_keep", 64'(rd_keep), 64'(mq[0].k));
      check("m_rd_last", 64'(rd_last), 64'(mq[0].l));
      check("m_rd_user", 64'(rd_user), 64'(mq[0].u));
    end
    check("m_beats", 64'(beat_cnt), 64'(m_beats));
    check("m_bytes", 64'(byte_cnt), 64'(m_bytes));
    check("m_pkts", 64'(pkt_cnt), 64'(m_pkts));
    check("m_err_stable", 64'(err_stable), 64'(m_err_s));
    check("m_err_keep", 64'(err_keep), 64'(m_err_k));
    if (mq.size() == DEPTH || !reset_n) check("m_tready_low", 64'(tready), 64'(0));
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic got;
    logic hs;
    got = 1'b0;
    tdata = d; tkeep = k; tlast = l; tuser = d[0]; tvalid = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      hs = tready;
      @(posedge clk);
      #1;
      got = hs;
    end
    check("send_hs", 64'(got), 64'(1));
  endtask

  task automatic pop_expect(input logic [DW-1:0] d);
    @(negedge clk);
    check("pop_data", 64'(rd_data), 64'(d));
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset(input logic [1:0] mode, input logic [7:0] thr);
    idle();
    rd_en = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cfg_mode = mode; cfg_rnd_thr = thr;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic t;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tready", 64'(tready), 64'(0));
    check("rst_fill", 64'(fill_level), 64'(0));
    check("rst_empty", 64'(rd_empty), 64'(1));
    check("rst_beats", 64'(beat_cnt), 64'(0));
    check("rst_errs", 64'({err_stable, err_keep}), 64'(0));

    // 1: ALWAYS, overfill then drain in order
    apply_reset(2'd0, 8'd0);
    for (int i = 0; i < 16; i++) send_beat(DW'(i), 4'hF, 1'b0);
    tdata = 32'd16; tuser = 1'b0; tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t1_tready_full", 64'(tready), 64'(0));
      check("t1_fill16", 64'(fill_level), 64'(16));
      tick();
    end
    fork
      begin
        for (int i = 16; i < 20; i++) send_beat(DW'(i), 4'hF, 1'b0);
        idle();
      end
      begin
        for (int j = 0; j < 16; j++) pop_expect(DW'(j));
      end
    join
    for (int j = 16; j < 20; j++) pop_expect(DW'(j));
    @(negedge clk);
    check("t1_empty", 64'(rd_empty), 64'(1));
    check("t1_beats", 64'(beat_cnt), 64'(20));
    check("t1_bytes", 64'(byte_cnt), 64'(80));
    check("t1_pkts", 64'(pkt_cnt), 64'(0));

    // 2: PATTERN 4 on / 2 off with tvalid held
    apply_reset(2'd2, 8'd0);
    tdata = 32'd100; tkeep = 4'hF; tlast = 1'b0; tuser = 1'b0; tvalid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      t = tready;
      check("t2_pattern", 64'(t), 64'((k % 6) < 4));
      tick();
      if (t) begin
        tdata = tdata + 32'd1;
        tuser = tdata[0];
      end
    end
    @(negedge clk);
    check("t2_beats8", 64'(beat_cnt), 64'(8));
    check("t2_on_again", 64'(tready), 64'(1));
    tick();
    idle();
    for (int j = 0; j < 9; j++) pop_expect(DW'(100 + j));

    // 3: PKT_GAP, two 3-beat packets
    apply_reset(2'd3, 8'd0);
    for (int p = 0; p < 2; p++) begin
      send_beat(DW'(p * 3), 4'hF, 1'b0);
      send_beat(DW'(p * 3 + 1), 4'hF, 1'b0);
      send_beat(DW'(p * 3 + 2), 4'h3, 1'b1);
      idle();
      for (int g = 0; g < 4; g++) begin
        @(negedge clk);
        check("t3_gap", 64'(tready), 64'(g == 3));
        tick();
      end
    end
    @(negedge clk);
    check("t3_pkts", 64'(pkt_cnt), 64'(2));
    check("t3_bytes", 64'(byte_cnt), 64'(20));
    check("t3_err_keep", 64'(err_keep), 64'(0));

    // 4: RANDOM threshold extremes and midpoint
    apply_reset(2'd1, 8'd0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tready) cnt++;
      tick();
    end
    check("t4_thr0", 64'(cnt), 64'(0));
    cfg_rnd_thr = 8'd128;
    tick();
    cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tready) cnt++;
      tick();
    end
    check("t4_thr128", 64'(cnt), 64'(50));
    cfg_rnd_thr = 8'd64;
    tick();
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tready) cnt++;
      tick();
    end
    check("t4_thr64_mix", 64'(cnt >= 40 && cnt <= 160), 64'(1));

    // 5: protocol checks
    apply_reset(2'd1, 8'd0);
    tdata = 32'd55; tkeep = 4'hF; tuser = 1'b1; tvalid = 1'b1;
    tick();
    @(negedge clk);
    check("t5_stall_ok", 64'(err_stable), 64'(0));
    tick();
    tvalid = 1'b0;
    tick();
    @(negedge clk);
    check("t5_drop_valid", 64'(err_stable), 64'(1));
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_stable", 64'(err_stable), 64'(0));
    tick();
    tdata = 32'd1; tvalid = 1'b1;
    tick();
    tdata = 32'd2;
    tick();
    @(negedge clk);
    check("t5_data_change", 64'(err_stable), 64'(1));
    tick();
    idle();
    cfg_mode = 2'd0;
    tick(); tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_both", 64'({err_stable, err_keep}), 64'(0));
    tick();
    send_beat(32'd7, 4'h7, 1'b0);
    idle();
    @(negedge clk);
    check("t5_keep_err", 64'(err_keep), 64'(1));
    tick();
    err_clr = 1'b1;
    send_beat(32'd8, 4'h0, 1'b1);
    err_clr = 1'b0;
    idle();
    @(negedge clk);
    check("t5_set_wins", 64'(err_keep), 64'(1));
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t5_clr_keep", 64'(err_keep), 64'(0));

    // 6: asynchronous reset mid-packet
    apply_reset(2'd0, 8'd0);
    for (int i = 0; i < 5; i++) send_beat(DW'(200 + i), 4'hF, 1'b0);
    idle();
    @(negedge clk);
    check("t6_fill5", 64'(fill_level), 64'(5));
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_tready", 64'(tready), 64'(0));
    check("t6_async_fill", 64'(fill_level), 64'(0));
    check("t6_async_empty", 64'(rd_empty), 64'(1));
    check("t6_async_beats", 64'(beat_cnt), 64'(0));
    check("t6_async_bytes", 64'(byte_cnt), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();
    send_beat(32'd300, 4'hF, 1'b0);
    send_beat(32'd301, 4'hF, 1'b1);
    idle();
    pop_expect(32'd300);
    pop_expect(32'd301);
    @(negedge clk);
    check("t6_beats", 64'(beat_cnt), 64'(2));
    check("t6_pkts", 64'(pkt_cnt), 64'(1));
    check("t6_empty", 64'(rd_empty), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
